// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the simple MIPS core.
//   - opcode and funct constants for the supported instruction subset
//   - ALU operation enum
//   - instruction field extraction helpers and sign extension
package mips_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic [5:0] inst_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [4:0] inst_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [4:0] inst_rd(input logic [31:0] inst);
    return inst[15:11];
  endfunction

  function automatic logic [5:0] inst_funct(input logic [31:0] inst);
    return inst[5:0];
  endfunction

  function automatic logic [15:0] inst_imm(input logic [31:0] inst);
    return inst[15:0];
  endfunction

  function automatic logic [25:0] inst_target(input logic [31:0] inst);
    return inst[25:0];
  endfunction

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit register file.
//   clk, rst_n      : clock, synchronous active-high clear of all registers
//   rs_addr/rs_data : combinational read port A
//   rt_addr/rt_data : combinational read port B
//   wr_en/wr_addr/wr_data : write port, committed on the rising edge
// r0 always reads zero and writes to it are dropped. A read in the same
// cycle as a write to that register returns the old contents.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];

endmodule

// File: rtl/simple_mips_cpu.sv
// simple_mips_cpu: single-cycle MIPS subset core (add/sub/and/or/slt, lw,
// sw, beq, j). One instruction is fetched, decoded and executed per clock.
//   clk, rst_n        : clock, synchronous active-high reset
//   instruction       : word fetched at inst_mem_rd_addr
//   data_mem_rd_data  : word read at data_mem_addr
//   inst_mem_rd_addr  : PC (byte address)
//   data_mem_addr     : ALU result (word index for the data memory)
//   data_mem_wrdata   : rt register value
//   memwrite_ctrl     : store strobe, memory writes at the rising edge
//   memread_ctrl      : load indicator
module simple_mips_cpu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] data_mem_rd_data,
  output logic [31:0] inst_mem_rd_addr,
  output logic [31:0] data_mem_addr,
  output logic [31:0] data_mem_wrdata,
  output logic        memwrite_ctrl,
  output logic        memread_ctrl
);

  logic [31:0] pc, pc_plus4, next_pc;
  logic [31:0] rs_data, rt_data, imm_sext, alu_b, alu_result, wr_data;
  logic [4:0]  dest_reg;
  logic        reg_write, mem_to_reg, use_imm, is_lw, is_sw, is_beq, is_j;
  alu_op_t     alu_op;

  assign imm_sext = sign_ext(inst_imm(instruction));
  assign pc_plus4 = pc + 32'd4;

  // Decode. Anything not recognised falls through with all defaults,
  // which is a NOP that simply advances the PC.
  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    use_imm    = 1'b1;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    alu_op     = ALU_ADD;
    dest_reg   = inst_rt(instruction);
    case (inst_op(instruction))
      OP_RTYPE: begin
        use_imm  = 1'b0;
        dest_reg = inst_rd(instruction);
        case (inst_funct(instruction))
          FUNCT_ADD: begin alu_op = ALU_ADD; reg_write = 1'b1; end
          FUNCT_SUB: begin alu_op = ALU_SUB; reg_write = 1'b1; end
          FUNCT_AND: begin alu_op = ALU_AND; reg_write = 1'b1; end
          FUNCT_OR:  begin alu_op = ALU_OR;  reg_write = 1'b1; end
          FUNCT_SLT: begin alu_op = ALU_SLT; reg_write = 1'b1; end
          default: ;
        endcase
      end
      OP_LW: begin
        is_lw      = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW:  is_sw = 1'b1;
      OP_BEQ: begin
        is_beq  = 1'b1;
        use_imm = 1'b0;
        alu_op  = ALU_SUB;
      end
      OP_J:   is_j = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = use_imm ? imm_sext : rt_data;

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = rs_data + alu_b;
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
      default: alu_result = rs_data + alu_b;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (is_beq && (rs_data == rt_data)) begin
      next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
    end else if (is_j) begin
      next_pc = {pc_plus4[31:28], inst_target(instruction), 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc <= '0;
    end else begin
      pc <= next_pc;
    end
  end

  assign wr_data = mem_to_reg ? data_mem_rd_data : alu_result;

  // Reset also gates the write enable so an instruction caught by a reset
  // edge cannot leave anything behind.
  mips_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (inst_rs(instruction)),
    .rt_addr (inst_rt(instruction)),
    .wr_en   (reg_write & ~rst_n),
    .wr_addr (dest_reg),
    .wr_data (wr_data),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  assign inst_mem_rd_addr = pc;
  assign data_mem_addr    = alu_result;
  assign data_mem_wrdata  = rt_data;
  assign memwrite_ctrl    = is_sw & ~rst_n;
  assign memread_ctrl     = is_lw & ~rst_n;

endmodule

// File: tb/tb_simple_mips_cpu.sv
module tb_simple_mips_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] data_mem_rd_data;
  logic [31:0] inst_mem_rd_addr;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_wrdata;
  logic        memwrite_ctrl;
  logic        memread_ctrl;

  simple_mips_cpu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction      (instruction),
    .data_mem_rd_data (data_mem_rd_data),
    .inst_mem_rd_addr (inst_mem_rd_addr),
    .data_mem_addr    (data_mem_addr),
    .data_mem_wrdata  (data_mem_wrdata),
    .memwrite_ctrl    (memwrite_ctrl),
    .memread_ctrl     (memread_ctrl)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- system memories ----------------
  logic [31:0] imem [32];
  logic [31:0] dmem [32];

  assign instruction      = imem[inst_mem_rd_addr[6:2]];
  assign data_mem_rd_data = dmem[data_mem_addr[4:0]];

  always @(posedge clk) begin
    if (memwrite_ctrl) dmem[data_mem_addr[4:0]] <= data_mem_wrdata;
  end

  // ---------------- bookkeeping ----------------
  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] funct);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'd2, target[25:0]};
  endfunction

  // ---------------- architectural model ----------------
  // ISA-level interpreter: holds PC, registers and data memory and executes
  // whole instructions. Evaluated on the falling edge: first the DUT's
  // visible outputs are compared against the model's current state, then
  // the model advances across the coming rising edge.
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [32];
  bit          m_valid;

  always @(negedge clk) begin
    logic [31:0] inst, a, b, sx, res, npc, addr;
    logic [5:0]  op, fn;
    int          rs, rt, rd;
    bit          wr;
    inst = imem[m_pc[6:2]];
    op = inst[31:26];
    fn = inst[5:0];
    rs = int'(inst[25:21]);
    rt = int'(inst[20:16]);
    rd = int'(inst[15:11]);
    a  = m_regs[rs];
    b  = m_regs[rt];
    sx = {{16{inst[15]}}, inst[15:0]};
    addr = a + sx;
    if (m_valid) begin
      check("pc", inst_mem_rd_addr, m_pc);
      check("memread", {31'd0, memread_ctrl}, {31'd0, (!rst_n) && op == 6'd35});
      check("memwrite", {31'd0, memwrite_ctrl}, {31'd0, (!rst_n) && op == 6'd43});
      if (!rst_n && (op == 6'd35 || op == 6'd43)) check("dmem_addr", data_mem_addr, addr);
      if (!rst_n && op == 6'd43) check("wrdata", data_mem_wrdata, b);
    end
    if (rst_n) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      npc = m_pc + 32'd4;
      wr  = 1'b0;
      res = 32'd0;
      case (op)
        6'd0: begin
          wr = 1'b1;
          case (fn)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: wr = 1'b0;
          endcase
          if (wr && rd != 0) m_regs[rd] = res;
        end
        6'd35: if (rt != 0) m_regs[rt] = m_dmem[addr[4:0]];
        6'd43: m_dmem[addr[4:0]] = b;
        6'd4:  if (a == b) npc = npc + (sx << 2);
        6'd2:  npc = {npc[31:28], inst[25:0], 2'b00};
        default: ;
      endcase
      m_pc = npc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_mem(input int idx, input logic [31:0] val);
    dmem[idx]   = val;
    m_dmem[idx] = val;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 32'd0;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
  endtask

  // Wait for the PC to reach a given address; leaves time at posedge+2.
  task automatic wait_pc(input logic [31:0] target, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (inst_mem_rd_addr == target) found = 1'b1;
    end
    if (!found) check(name, inst_mem_rd_addr, target);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] trace1 [7];
  logic [31:0] trace2 [4];

  initial begin
    tests   = 0;
    fails   = 0;
    m_valid = 1'b0;
    m_pc    = 32'd0;
    rst_n   = 1'b1;
    for (int i = 0; i < 32; i++) set_mem(i, 32'hA0 + i);
    set_mem(0, 32'd1);
    set_mem(1, 32'd5);
    set_mem(2, 32'd5);
    set_mem(3, 32'h33);

    // Phase 1: loads, add, jump back to 0.
    clear_imem();
    imem[0] = enc_i(6'd35, 0, 1, 0);
    imem[1] = enc_i(6'd35, 0, 2, 1);
    imem[2] = enc_i(6'd35, 0, 4, 2);
    imem[3] = enc_r(1, 2, 3, 6'h20);
    imem[4] = enc_j(0);
    release_reset();
    trace1 = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd0, 32'd4};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("p1_pc", inst_mem_rd_addr, trace1[i]);
      if (i < 3) begin
        check("p1_memread", {31'd0, memread_ctrl}, 32'd1);
        check("p1_lw_addr", data_mem_addr, i);
      end
    end
    #1;
    check("model_r1", m_regs[1], 32'd1);
    check("model_r3", m_regs[3], 32'd6);

    // Phase 2: r0 discard, logic ops, signed slt, NOPs, store, branches.
    assert_reset();
    clear_imem();
    imem[0]  = enc_i(6'd35, 0, 1, 0);
    imem[1]  = enc_i(6'd35, 0, 2, 1);
    imem[2]  = enc_i(6'd35, 0, 4, 2);
    imem[3]  = enc_r(1, 2, 0, 6'h20);
    imem[4]  = enc_i(6'd43, 0, 0, 4);
    imem[5]  = enc_r(1, 2, 5, 6'h24);
    imem[6]  = enc_r(1, 2, 6, 6'h25);
    imem[7]  = enc_r(1, 2, 7, 6'h2A);
    imem[8]  = enc_r(1, 2, 8, 6'h22);
    imem[9]  = enc_r(8, 1, 9, 6'h2A);
    imem[10] = enc_i(6'd43, 0, 5, 5);
    imem[11] = enc_i(6'd43, 0, 6, 6);
    imem[12] = enc_i(6'd43, 0, 7, 7);
    imem[13] = enc_i(6'd43, 0, 8, 8);
    imem[14] = enc_i(6'd43, 0, 9, 9);
    imem[15] = 32'hFC00_0000;
    imem[16] = enc_r(1, 2, 1, 6'h27);
    imem[17] = enc_i(6'd43, 0, 1, 10);
    imem[18] = enc_r(1, 2, 3, 6'h20);
    imem[19] = enc_i(6'd43, 0, 3, 3);
    imem[20] = enc_i(6'd4, 4, 3, 1);
    imem[21] = enc_r(3, 1, 3, 6'h22);
    imem[22] = enc_i(6'd4, 4, 3, -5);
    release_reset();
    wait_pc(32'd80, "wait_pc80");
    trace2 = '{32'd80, 32'd84, 32'd88, 32'd72};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("p2_branch_pc", inst_mem_rd_addr, trace2[i]);
    end
    repeat (30) @(posedge clk);
    #2;
    check("dmem3_add", dmem[3], 32'd6);
    check("dmem4_r0", dmem[4], 32'd0);
    check("dmem5_and", dmem[5], 32'd1);
    check("dmem6_or", dmem[6], 32'd5);
    check("dmem7_slt", dmem[7], 32'd1);
    check("dmem8_sub", dmem[8], 32'hFFFF_FFFC);
    check("dmem9_slt_signed", dmem[9], 32'd1);
    check("dmem10_nop", dmem[10], 32'd1);

    // Phase 3: reset lands on the SW in the loop; the store must not happen.
    assert_reset();
    set_mem(3, 32'h33);
    release_reset();
    wait_pc(32'd76, "wait_pc76");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sw_memwrite", {31'd0, memwrite_ctrl}, 32'd0);
    @(negedge clk);
    check("rst_pc0", inst_mem_rd_addr, 32'd0);
    check("rst_no_store", dmem[3], 32'h33);

    // Phase 4: registers must read zero after reset.
    clear_imem();
    imem[0] = enc_i(6'd43, 0, 1, 11);
    imem[1] = enc_i(6'd43, 0, 3, 12);
    imem[2] = enc_i(6'd43, 0, 9, 13);
    imem[3] = enc_j(3);
    release_reset();
    repeat (10) @(posedge clk);
    #2;
    check("clr_r1", dmem[11], 32'd0);
    check("clr_r3", dmem[12], 32'd0);
    check("clr_r9", dmem[13], 32'd0);
    check("j_self_pc", inst_mem_rd_addr, 32'd12);
    for (int i = 0; i < 32; i++) check("dmem_vs_model", dmem[i], m_dmem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_mips_cpu.md
# simple_mips_cpu

Single-cycle 32-bit MIPS subset processor core: fetches one instruction per clock from an external instruction memory, executes it, and updates the PC and the register file on the same rising edge. Instruction and data memories live outside the block. The core drives addresses and write data combinationally and receives instruction and load data combinationally, which makes it the CPU of the simple MIPS system.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-high (asserted when 1).
- instruction  input  32  instruction word at inst_mem_rd_addr (combinational fetch).
- data_mem_rd_data  input  32  data word at data_mem_addr (combinational read).
- inst_mem_rd_addr  output  32  PC, byte address (memory indexes by PC>>2).
- data_mem_addr  output  32  ALU result = rs + sign-extended imm, used as a word index (no scaling).
- data_mem_wrdata  output  32  register rt value, for SW.
- memwrite_ctrl  output  1  high during SW; memory writes on the rising edge.
- memread_ctrl  output  1  high during LW.

## Operation
- Register file: 32×32. r0 reads as 0 and ignores writes. Two combinational read ports (rs, rt) and one write port.
- Supported instructions:
  - R-type (op 0) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Writes rd.
  - LW (op 35): rt ← data_mem_rd_data.
  - SW (op 43).
  - BEQ (op 4): if rs==rt, PC ← PC+4 + (sext(imm)<<2).
  - J (op 2): PC ← {PC+4[31:28], target, 2'b00}.
- Address arithmetic: 32-bit wrap-around, no overflow exceptions.
- Default next PC is PC+4.
- Unsupported opcodes and funct codes execute as NOPs: no register write, memwrite_ctrl=0, PC+4.
- LW to r0 and R-type writes to r0 are discarded.

## Timing
- One instruction per cycle. The instruction is decoded combinationally. At the rising edge the core updates the PC, performs the register write, and the memory performs the SW write.
- Register read during the same cycle as a write to that register returns the old value. The following instruction sees the new value.
- Reset (rst_n=1 at an edge): PC ← 0 and all registers ← 0.
- While reset is asserted, memwrite_ctrl=0 and memread_ctrl=0, and no register writes occur.
- inst_mem_rd_addr=0 from the first edge after reset is asserted.
- Reset asserted mid-program aborts the current instruction. No partial writes occur.
- Execution resumes at PC 0 on the first edge after rst_n returns to 0.
- data_mem_addr and data_mem_wrdata are don't-care when unused, but must be deterministic (ALU result and rt).

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
  - funct constants
  - ALU-operation enum
  - instruction field slices (op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0])
- One sub-module, mips_regfile (32×32, r0 hardwired zero, synchronous reset clear). Control, ALU and PC logic stay in the top.

## Test plan
- Load sequence:
  - Stimulus: data mem [0]=1, [1]=5, [2]=5. Run LW r1,0(r0); LW r2,1(r0); LW r4,2(r0).
  - Response: data_mem_addr = 0, 1, 2 with memread_ctrl=1. r1=1, r2=5, r4=5. inst_mem_rd_addr = 0, 4, 8.
- ADD: ADD r3,r1,r2 → r3=6 at PC=12.
- Jump: J 0 at PC=16 → next inst_mem_rd_addr=0, and the program loops.
- Store: SW r3,3(r0) → memwrite_ctrl=1, data_mem_addr=3, data_mem_wrdata=6; memory word 3 = 6.
- Branch:
  - BEQ r4,r3 with r4=5, r3=6 → not taken (PC+4).
  - Set r3=5 and repeat with offset −5 → taken, PC = PC+4−20.
- Reset and r0:
  - Assert reset mid-loop → PC=0 and all registers 0. memwrite_ctrl stays 0 even if the current instruction is SW.
  - ADD r0,r1,r2 → r0 still reads 0.
